// File: rtl/weight_ram_loader_pkg.sv
// Shared CNN weight-path parameters and the loader state encoding.
package weight_ram_loader_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int KERNEL_SIZE_MAX = 5;
    localparam int PARA_KERNEL     = 4;
    localparam int WADDR_WIDTH     = 9;

    // Derived widths: one kernel row, one kernel, and the whole parallel set.
    localparam int ROW_W       = $clog2(KERNEL_SIZE_MAX);
    localparam int ROW_BITS    = KERNEL_SIZE_MAX * DATA_WIDTH;
    localparam int KERNEL_BITS = KERNEL_SIZE_MAX * ROW_BITS;
    localparam int SET_BITS    = KERNEL_BITS * PARA_KERNEL;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(KERNEL_SIZE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2,
        READY   = 2'd3
    } state_t;

endpackage

// File: rtl/weight_row_mux.sv
// Selects one row of one captured kernel for writing into that kernel's RAM.
module weight_row_mux
    import weight_ram_loader_pkg::*;
(
    input  logic [KERNEL_BITS-1:0] kernel_words,
    input  logic [ROW_W-1:0]       row,
    output logic [ROW_BITS-1:0]    row_words
);

    // Row select; row codes past the last row (never produced) yield zero.
    always_comb begin
        row_words = '0;
        for (int r = 0; r < KERNEL_SIZE_MAX; r++) begin
            if (row == ROW_W'(r)) begin
                row_words = kernel_words[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

endmodule

// File: rtl/weight_ram_loader.sv
// Captures a full weight set on a rising edge of weight_data_done and writes
// it one kernel row per cycle into all PARA_KERNEL weight RAMs in parallel.
//
// Handshake: weight_data_done is a level "valid" from the producer; data and
// addresses are only sampled on its rising edge. init_weight_ram_ready is the
// acknowledge and stays high until the producer drops weight_data_done. A new
// set needs done low, then high again, once ready has been seen; rises seen
// while a set is in flight are dropped.
module weight_ram_loader
    import weight_ram_loader_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SET_BITS-1:0]               weight_data,
    input  logic [WADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr,
    input  logic                              weight_data_done,
    output logic                              init_weight_ram_ready,
    output logic                              busy,
    output logic [PARA_KERNEL-1:0]            wram_we,
    output logic [WADDR_WIDTH*PARA_KERNEL-1:0] wram_addr,
    output logic [ROW_BITS*PARA_KERNEL-1:0]   wram_wdata,
    output logic [7:0]                        load_count,
    output state_t                            dbg_state
);

    state_t                             state;
    logic                               done_q;
    logic                               armed;
    logic                               rise;
    logic [ROW_W-1:0]                   row;
    logic [SET_BITS-1:0]                cap_data;
    logic [WADDR_WIDTH*PARA_KERNEL-1:0] cap_addr;
    logic [ROW_BITS-1:0]                row_words [PARA_KERNEL];

    // armed stays low after reset until done has been seen low, so a done
    // level held across reset is not mistaken for a fresh rising edge.
    assign rise      = weight_data_done & ~done_q & armed;
    assign dbg_state = state;

    // One row mux per kernel, all driven by the shared row counter.
    for (genvar k = 0; k < PARA_KERNEL; k++) begin : g_row_mux
        weight_row_mux u_row_mux (
            .kernel_words (cap_data[k*KERNEL_BITS +: KERNEL_BITS]),
            .row          (row),
            .row_words    (row_words[k])
        );
    end

    // Control FSM with registered RAM-side outputs and the completed-set counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= IDLE;
            done_q                <= 1'b0;
            armed                 <= 1'b0;
            row                   <= '0;
            cap_data              <= '0;
            cap_addr              <= '0;
            init_weight_ram_ready <= 1'b0;
            busy                  <= 1'b0;
            wram_we               <= '0;
            wram_addr             <= '0;
            wram_wdata            <= '0;
            load_count            <= '0;
        end else begin
            done_q <= weight_data_done;
            armed  <= armed | ~weight_data_done;
            case (state)
                IDLE: begin
                    init_weight_ram_ready <= 1'b0;
                    wram_we               <= '0;
                    busy                  <= 1'b0;
                    if (rise) begin
                        cap_data <= weight_data;
                        cap_addr <= write_weight_data_addr;
                        busy     <= 1'b1;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    busy  <= 1'b1;
                    row   <= '0;
                    state <= WRITE;
                end
                WRITE: begin
                    busy    <= 1'b1;
                    wram_we <= '1;
                    for (int k = 0; k < PARA_KERNEL; k++) begin
                        // Address arithmetic wraps silently at the RAM depth.
                        wram_addr[k*WADDR_WIDTH +: WADDR_WIDTH] <=
                            cap_addr[k*WADDR_WIDTH +: WADDR_WIDTH] + WADDR_WIDTH'(row);
                        wram_wdata[k*ROW_BITS +: ROW_BITS] <= row_words[k];
                    end
                    if (row == LAST_ROW) begin
                        load_count <= load_count + 8'd1;
                        state      <= READY;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                READY: begin
                    init_weight_ram_ready <= 1'b1;
                    busy                  <= 1'b0;
                    wram_we               <= '0;
                    if (!weight_data_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Self-checking bench for weight_ram_loader: randomized weight sets compared
// against a per-kernel array model and an expected-write queue.
module tb_weight_ram_loader;
    import weight_ram_loader_pkg::*;

    localparam int REC_K = WADDR_WIDTH + ROW_BITS;
    localparam int REC_W = PARA_KERNEL * REC_K;

    logic                               clk = 1'b0;
    logic                               rst = 1'b0;
    logic [SET_BITS-1:0]                weight_data = '0;
    logic [WADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr = '0;
    logic                               weight_data_done = 1'b0;
    logic                               init_weight_ram_ready;
    logic                               busy;
    logic [PARA_KERNEL-1:0]             wram_we;
    logic [WADDR_WIDTH*PARA_KERNEL-1:0] wram_addr;
    logic [ROW_BITS*PARA_KERNEL-1:0]    wram_wdata;
    logic [7:0]                         load_count;
    state_t                             dbg_state;

    weight_ram_loader dut (
        .clk                    (clk),
        .rst                    (rst),
        .weight_data            (weight_data),
        .write_weight_data_addr (write_weight_data_addr),
        .weight_data_done       (weight_data_done),
        .init_weight_ram_ready  (init_weight_ram_ready),
        .busy                   (busy),
        .wram_we                (wram_we),
        .wram_addr              (wram_addr),
        .wram_wdata             (wram_wdata),
        .load_count             (load_count),
        .dbg_state              (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the set as words[kernel][row][col] plus base addresses.
    logic [DATA_WIDTH-1:0]  cur_w    [PARA_KERNEL][KERNEL_SIZE_MAX][KERNEL_SIZE_MAX];
    logic [WADDR_WIDTH-1:0] cur_base [PARA_KERNEL];
    logic [7:0]             exp_count = 8'd0;
    logic [REC_W-1:0]       exp_q [$];

    // Driver: pack the model arrays onto the input buses.
    task automatic apply_inputs();
        for (int k = 0; k < PARA_KERNEL; k++) begin
            write_weight_data_addr[k*WADDR_WIDTH +: WADDR_WIDTH] = cur_base[k];
            for (int r = 0; r < KERNEL_SIZE_MAX; r++)
                for (int c = 0; c < KERNEL_SIZE_MAX; c++)
                    weight_data[k*KERNEL_BITS + r*ROW_BITS + c*DATA_WIDTH +: DATA_WIDTH] = cur_w[k][r][c];
        end
    endtask

    task automatic randomize_set();
        for (int k = 0; k < PARA_KERNEL; k++) begin
            cur_base[k] = WADDR_WIDTH'($urandom_range(0, (1 << WADDR_WIDTH) - 1));
            for (int r = 0; r < KERNEL_SIZE_MAX; r++)
                for (int c = 0; c < KERNEL_SIZE_MAX; c++)
                    cur_w[k][r][c] = DATA_WIDTH'($urandom_range(0, 65535));
        end
    endtask

    // Scoreboard: one record per expected write cycle, all kernels side by side.
    task automatic push_expected(input int nrows);
        logic [REC_W-1:0] rec;
        int a;
        for (int r = 0; r < nrows; r++) begin
            rec = '0;
            for (int k = 0; k < PARA_KERNEL; k++) begin
                a = (int'(cur_base[k]) + r) % (1 << WADDR_WIDTH);
                rec[k*REC_K +: WADDR_WIDTH] = WADDR_WIDTH'(a);
                for (int c = 0; c < KERNEL_SIZE_MAX; c++)
                    rec[k*REC_K + WADDR_WIDTH + c*DATA_WIDTH +: DATA_WIDTH] = cur_w[k][r][c];
            end
            exp_q.push_back(rec);
        end
    endtask

    function automatic logic [REC_W-1:0] observed_rec();
        logic [REC_W-1:0] rec;
        rec = '0;
        for (int k = 0; k < PARA_KERNEL; k++) begin
            rec[k*REC_K +: WADDR_WIDTH]        = wram_addr[k*WADDR_WIDTH +: WADDR_WIDTH];
            rec[k*REC_K + WADDR_WIDTH +: ROW_BITS] = wram_wdata[k*ROW_BITS +: ROW_BITS];
        end
        return rec;
    endfunction

    // One load: done rises, cycles n=0.. after the rise edge are observed.
    // drop_at: first cycle done is sampled low; churn: change inputs and pulse
    // done during WRITE; rst_at: cycle after which reset is asserted (-1 none).
    task automatic run_load(input int drop_at, input bit churn, input int rst_at);
        int nrows;
        logic [PARA_KERNEL-1:0] exp_we;
        logic exp_ready, exp_busy;
        logic [REC_W-1:0] exp_rec, obs;
        weight_data_done = 1'b0;
        apply_inputs();
        @(posedge clk); @(negedge clk);
        nrows = (rst_at < 0) ? KERNEL_SIZE_MAX : rst_at - 1;
        if (nrows > KERNEL_SIZE_MAX) nrows = KERNEL_SIZE_MAX;
        push_expected(nrows);
        // Reset clears the counter along with every other output.
        exp_count = (rst_at < 0) ? exp_count + 8'd1 : 8'd0;
        weight_data_done = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            @(posedge clk); @(negedge clk);
            exp_we    = (n >= 2 && n <= 6 && (rst_at < 0 || n <= rst_at)) ? '1 : '0;
            exp_busy  = (n <= 6 && (rst_at < 0 || n <= rst_at));
            exp_ready = (rst_at < 0 && n >= 7 && (n == 7 || n <= drop_at));
            checks++;
            if (wram_we !== exp_we) begin
                failures++;
                $display("FAIL we n=%0d got=%h exp=%h", n, wram_we, exp_we);
            end
            if (wram_we !== '0) begin
                checks++;
                obs = observed_rec();
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write n=%0d got=%h exp=none", n, obs);
                end else begin
                    exp_rec = exp_q.pop_front();
                    if (obs !== exp_rec) begin
                        failures++;
                        $display("FAIL write_rec n=%0d got=%h exp=%h", n, obs, exp_rec);
                    end
                end
            end
            checks++;
            if (init_weight_ram_ready !== exp_ready) begin
                failures++;
                $display("FAIL ready n=%0d got=%b exp=%b", n, init_weight_ram_ready, exp_ready);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy n=%0d got=%b exp=%b", n, busy, exp_busy);
            end
            if (n >= 7) begin
                checks++;
                if (load_count !== exp_count) begin
                    failures++;
                    $display("FAIL load_count n=%0d got=%0d exp=%0d", n, load_count, exp_count);
                end
            end
            // Drive for the next edge
            if (n == drop_at - 1) weight_data_done = 1'b0;
            if (churn && n >= 2 && n <= 5) begin
                randomize_set();
                apply_inputs();
                if (n == 2) weight_data_done = 1'b0;
                if (n == 3) weight_data_done = 1'b1;
            end
            if (n == rst_at) rst = 1'b0;
            if (rst_at >= 0 && n == rst_at + 2) rst = 1'b1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        weight_data_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        weight_data_done = 1'b1;
        randomize_set();
        apply_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wram_we, wram_addr, wram_wdata, init_weight_ram_ready, busy, load_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%h ready=%b busy=%b cnt=%0d exp=all zero",
                     wram_we, init_weight_ram_ready, busy, load_count);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        rst = 1'b1;
        // done held high across reset release must not start a load
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (init_weight_ram_ready !== 1'b0 || wram_we !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL held_done i=%0d got ready=%b we=%h busy=%b exp=0", i,
                         init_weight_ram_ready, wram_we, busy);
            end
        end
        weight_data_done = 1'b0;
        exp_count = 8'd0;
    endtask

    task automatic test_single_load();
        for (int k = 0; k < PARA_KERNEL; k++) begin
            cur_base[k] = WADDR_WIDTH'(k * 25);
            for (int r = 0; r < KERNEL_SIZE_MAX; r++)
                for (int c = 0; c < KERNEL_SIZE_MAX; c++)
                    cur_w[k][r][c] = DATA_WIDTH'(k * 100 + r * 5 + c);
        end
        run_load(10, 1'b0, -1);
    endtask

    task automatic test_addr_wrap();
        randomize_set();
        cur_base[0] = WADDR_WIDTH'(510);
        run_load(10, 1'b0, -1);
    endtask

    task automatic test_done_drop_mid_write();
        randomize_set();
        run_load(3, 1'b0, -1);
    endtask

    task automatic test_input_churn();
        randomize_set();
        run_load(10, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            randomize_set();
            run_load($urandom_range(0, 1) ? 10 : $urandom_range(1, 7), 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid_write();
        randomize_set();
        run_load(10, 1'b0, 4);
        randomize_set();
        run_load(10, 1'b0, -1);
    endtask

    task automatic test_count_wrap();
        while (exp_count != 8'd0) begin
            randomize_set();
            run_load(10, 1'b0, -1);
        end
        checks++;
        if (load_count !== 8'd0) begin
            failures++;
            $display("FAIL count_wrap got=%0d exp=0", load_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_addr_wrap();
        test_done_drop_mid_write();
        test_input_churn();
        test_back_to_back();
        test_reset_mid_write();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
